// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - single-port RAM arbiter between the stack CPU and a loader/debug port
//
// The CPU owns the RAM by default. A loader request freezes the CPU (cpu_haltN low),
// hands the RAM to the loader for up to MAX_BURST accesses, then re-presents the CPU
// address for one cycle so the CPU resumes with correct read data.
//
// Ports:
//   clk, resetN                 clock (rising edge), asynchronous active-low reset
//   sys_haltN                   board halt, ANDed into cpu_haltN
//   cpu_haltN                   CPU run enable
//   cpu_readWriteN/address/data_out   CPU RAM request (1 = read)
//   ld_req, ld_readWriteN, ld_address, ld_data_out   loader RAM request
//   ld_grant                    loader owns the RAM this cycle (registered)
//   ld_valid, ld_data_in        read data of the previous granted loader read
//   ram_readWriteN/address/data_out   to RAM
//   ram_data_in                 from RAM, valid one cycle after the address
module ram_arbiter #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16,
  parameter int CPU_SLOT  = 4
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              sys_haltN,
  output logic              cpu_haltN,
  input  logic              cpu_readWriteN,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_data_out,
  input  logic              ld_req,
  input  logic              ld_readWriteN,
  input  logic [ADDR_W-1:0] ld_address,
  input  logic [DATA_W-1:0] ld_data_out,
  output logic              ld_grant,
  output logic              ld_valid,
  output logic [DATA_W-1:0] ld_data_in,
  output logic              ram_readWriteN,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_out,
  input  logic [DATA_W-1:0] ram_data_in
);

  localparam logic [1:0] ST_CPU     = 2'd0;
  localparam logic [1:0] ST_DRAIN   = 2'd1;
  localparam logic [1:0] ST_LOAD    = 2'd2;
  localparam logic [1:0] ST_RESTORE = 2'd3;

  localparam int SLOT_W  = (CPU_SLOT < 2) ? 1 : $clog2(CPU_SLOT + 1);
  // burst_cnt only needs to reach MAX_BURST-1; the grant ends on that access.
  localparam int BURST_W = (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST);

  localparam logic [SLOT_W-1:0]  SLOT_INIT  = SLOT_W'(CPU_SLOT);
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'((MAX_BURST == 0) ? 0 : MAX_BURST - 1);

  logic [1:0]         state;
  logic [1:0]         state_next;
  logic [SLOT_W-1:0]  slot_cnt;
  logic [BURST_W-1:0] burst_cnt;
  logic               rw_sel;

  always_comb begin
    state_next = state;
    case (state)
      ST_CPU: begin
        if (ld_req && (slot_cnt == '0)) state_next = ST_DRAIN;
      end
      ST_DRAIN: state_next = ST_LOAD;
      ST_LOAD: begin
        if (!ld_req) begin
          state_next = ST_RESTORE;
        end else if ((MAX_BURST != 0) && (burst_cnt == BURST_LAST)) begin
          state_next = ST_RESTORE;
        end
      end
      ST_RESTORE: state_next = ST_CPU;
      default:    state_next = ST_CPU;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= ST_CPU;
      slot_cnt  <= '0;
      burst_cnt <= '0;
      ld_grant  <= 1'b0;
      ld_valid  <= 1'b0;
    end else begin
      state    <= state_next;
      ld_grant <= (state_next == ST_LOAD);
      ld_valid <= (state == ST_LOAD) && ld_req && ld_readWriteN;
      case (state)
        ST_CPU: begin
          if (slot_cnt != '0) slot_cnt <= slot_cnt - 1'b1;
        end
        ST_DRAIN: burst_cnt <= '0;
        ST_LOAD: begin
          if (ld_req) burst_cnt <= burst_cnt + 1'b1;
        end
        ST_RESTORE: slot_cnt <= SLOT_INIT;
        default: ;
      endcase
    end
  end

  // DRAIN and RESTORE keep the CPU address on the bus as a read only: the CPU's
  // last write has already committed, and RESTORE refreshes its read data.
  always_comb begin
    ram_address  = cpu_address;
    ram_data_out = cpu_data_out;
    rw_sel       = 1'b1;
    case (state)
      ST_CPU: rw_sel = cpu_readWriteN;
      ST_LOAD: begin
        ram_address  = ld_address;
        ram_data_out = ld_data_out;
        rw_sel       = ld_req ? ld_readWriteN : 1'b1;
      end
      default: rw_sel = 1'b1;
    endcase
  end

  // No RAM write can occur while reset is held, whatever the CPU is driving.
  assign ram_readWriteN = rw_sel | ~resetN;
  assign cpu_haltN      = sys_haltN & (state == ST_CPU);
  assign ld_data_in     = ram_data_in;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - self-checking bench for ram_arbiter with a behavioural RAM
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       resetN;
  logic       sys_haltN;
  logic       cpu_haltN;
  logic       cpu_readWriteN;
  logic [7:0] cpu_address;
  logic [7:0] cpu_data_out;
  logic       ld_req;
  logic       ld_readWriteN;
  logic [7:0] ld_address;
  logic [7:0] ld_data_out;
  logic       ld_grant;
  logic       ld_valid;
  logic [7:0] ld_data_in;
  logic       ram_readWriteN;
  logic [7:0] ram_address;
  logic [7:0] ram_data_out;
  logic [7:0] ram_data_in;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_BURST(16), .CPU_SLOT(4)) dut (
    .clk(clk), .resetN(resetN), .sys_haltN(sys_haltN), .cpu_haltN(cpu_haltN),
    .cpu_readWriteN(cpu_readWriteN), .cpu_address(cpu_address), .cpu_data_out(cpu_data_out),
    .ld_req(ld_req), .ld_readWriteN(ld_readWriteN), .ld_address(ld_address),
    .ld_data_out(ld_data_out), .ld_grant(ld_grant), .ld_valid(ld_valid),
    .ld_data_in(ld_data_in), .ram_readWriteN(ram_readWriteN), .ram_address(ram_address),
    .ram_data_out(ram_data_out), .ram_data_in(ram_data_in)
  );

  // Synchronous single-port RAM, read-before-write.
  logic [7:0] mem [256];
  logic [7:0] exp_mem [256];
  int         wr20_cnt = 0;

  always @(posedge clk) begin
    if (!ram_readWriteN) begin
      mem[ram_address] <= ram_data_out;
      if (ram_address == 8'h20) wr20_cnt++;
    end
    ram_data_in <= mem[ram_address];
  end

  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_q [$];
  bit         pend = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Sample point of each cycle; also runs the loader read-data scoreboard.
  task automatic settle();
    #2;
    if (!resetN) begin
      exp_q.delete();
      pend = 1'b0;
    end else begin
      if (pend || ld_valid) begin
        chk("ld_valid", 32'(ld_valid), 32'(pend));
        if (pend && (exp_q.size() > 0)) chk("ld_data_in", 32'(ld_data_in), 32'(exp_q.pop_front()));
      end
      pend = ld_grant && ld_req && ld_readWriteN;
      if (pend) exp_q.push_back(exp_mem[ld_address]);
    end
  endtask

  typedef struct {
    logic       ld_req;
    logic       ld_rw;
    logic [7:0] ld_addr;
    logic [7:0] ld_data;
    logic       cpu_rw;
    logic [7:0] cpu_addr;
    logic [7:0] cpu_data;
    logic       e_halt;
    logic       e_grant;
    logic       e_rw;
    logic [7:0] e_addr;
  } vec_t;

  function automatic vec_t mk(input logic lr, input logic lrw, input logic [7:0] la,
                              input logic [7:0] ld, input logic crw, input logic [7:0] ca,
                              input logic [7:0] cd, input logic eh, input logic eg,
                              input logic erw, input logic [7:0] ea);
    vec_t v;
    v.ld_req = lr;   v.ld_rw = lrw;  v.ld_addr = la;  v.ld_data = ld;
    v.cpu_rw = crw;  v.cpu_addr = ca; v.cpu_data = cd;
    v.e_halt = eh;   v.e_grant = eg; v.e_rw = erw;    v.e_addr = ea;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t       vecs [$];
    logic [7:0] rb [6];
    int         g1;
    int         gap;
    int         phase;

    rb = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h20};
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 8'(i) ^ 8'h5A;
      exp_mem[i] = 8'(i) ^ 8'h5A;
    end

    // Idle CPU reads, then a loader burst of five writes and one read, with a CPU
    // write landing in the same cycle the request rises.
    vecs.push_back(mk(0, 1, 8'h00, 8'h00, 1, 8'h03, 8'h00, 1, 0, 1, 8'h03));
    vecs.push_back(mk(0, 1, 8'h00, 8'h00, 1, 8'h03, 8'h00, 1, 0, 1, 8'h03));
    vecs.push_back(mk(1, 0, 8'h10, 8'hA0, 0, 8'h20, 8'h55, 1, 0, 0, 8'h20));
    vecs.push_back(mk(1, 0, 8'h10, 8'hA0, 0, 8'h20, 8'h55, 0, 0, 1, 8'h20));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(1, 0, 8'h10 + 8'(i), 8'hA0 + 8'(i), 0, 8'h20, 8'h55, 0, 1, 0, 8'h10 + 8'(i)));
    vecs.push_back(mk(1, 1, 8'h10, 8'h00, 0, 8'h20, 8'h55, 0, 1, 1, 8'h10));
    vecs.push_back(mk(0, 1, 8'h10, 8'h00, 1, 8'h12, 8'h00, 0, 1, 1, 8'h10));
    vecs.push_back(mk(0, 1, 8'h10, 8'h00, 1, 8'h12, 8'h00, 0, 0, 1, 8'h12));
    vecs.push_back(mk(0, 1, 8'h00, 8'h00, 1, 8'h12, 8'h00, 1, 0, 1, 8'h12));

    resetN = 1'b0; sys_haltN = 1'b1;
    cpu_readWriteN = 1'b0; cpu_address = 8'h20; cpu_data_out = 8'hEE;
    ld_req = 1'b0; ld_readWriteN = 1'b1; ld_address = 8'h00; ld_data_out = 8'h00;

    repeat (2) @(posedge clk);
    #3;
    chk("reset ld_grant", 32'(ld_grant), 32'(0));
    chk("reset ld_valid", 32'(ld_valid), 32'(0));
    chk("reset ram_rwN", 32'(ram_readWriteN), 32'(1));
    chk("reset cpu_haltN", 32'(cpu_haltN), 32'(1));

    next_cycle();
    resetN = 1'b1; cpu_readWriteN = 1'b1; cpu_address = 8'h03;
    settle();

    next_cycle();
    sys_haltN = 1'b0;
    settle();
    chk("sys_haltN gates cpu_haltN", 32'(cpu_haltN), 32'(0));
    next_cycle();
    sys_haltN = 1'b1;
    settle();

    foreach (vecs[k]) begin
      next_cycle();
      ld_req = vecs[k].ld_req; ld_readWriteN = vecs[k].ld_rw;
      ld_address = vecs[k].ld_addr; ld_data_out = vecs[k].ld_data;
      cpu_readWriteN = vecs[k].cpu_rw; cpu_address = vecs[k].cpu_addr;
      cpu_data_out = vecs[k].cpu_data;
      settle();
      chk($sformatf("row%0d cpu_haltN", k), 32'(cpu_haltN), 32'(vecs[k].e_halt));
      chk($sformatf("row%0d ld_grant", k), 32'(ld_grant), 32'(vecs[k].e_grant));
      chk($sformatf("row%0d ram_rwN", k), 32'(ram_readWriteN), 32'(vecs[k].e_rw));
      chk($sformatf("row%0d ram_address", k), 32'(ram_address), 32'(vecs[k].e_addr));
      if (vecs[k].e_grant && vecs[k].ld_req && !vecs[k].ld_rw) exp_mem[vecs[k].ld_addr] = vecs[k].ld_data;
      if (vecs[k].e_halt && !vecs[k].cpu_rw) exp_mem[vecs[k].cpu_addr] = vecs[k].cpu_data;
    end
    chk("post-resume ram_data_in", 32'(ram_data_in), 32'(exp_mem[8'h12]));

    for (int i = 0; i <= 6; i++) begin
      next_cycle();
      ld_req = 1'b0; cpu_readWriteN = 1'b1;
      if (i < 6) cpu_address = rb[i];
      settle();
      if (i > 0) chk($sformatf("readback %0h", rb[i-1]), 32'(ram_data_in), 32'(exp_mem[rb[i-1]]));
    end
    chk("single write to 0x20", 32'(wr20_cnt), 32'(1));

    g1 = 0; gap = 0; phase = 0;
    for (int c = 0; c < 40; c++) begin
      next_cycle();
      ld_req = 1'b1; ld_readWriteN = 1'b1; ld_address = 8'h10 + 8'(c % 5);
      cpu_readWriteN = 1'b1; cpu_address = 8'h14;
      settle();
      case (phase)
        0: if (ld_grant) begin phase = 1; g1 = 1; end
        1: if (ld_grant) g1++; else phase = 2;
        2: if (ld_grant) phase = 3; else if (cpu_haltN) gap++;
        default: ;
      endcase
    end
    chk("burst length", 32'(g1), 32'(16));
    chk("cpu slot after burst", 32'(gap >= 4), 32'(1));
    chk("re-grant", 32'(phase == 3), 32'(1));

    next_cycle();
    ld_req = 1'b1; ld_readWriteN = 1'b0; ld_address = 8'h30; ld_data_out = 8'h99;
    #1;
    chk("grant before reset", 32'(ld_grant), 32'(1));
    resetN = 1'b0;
    #1;
    chk("async reset ld_grant", 32'(ld_grant), 32'(0));
    chk("async reset ram_rwN", 32'(ram_readWriteN), 32'(1));
    chk("async reset ld_valid", 32'(ld_valid), 32'(0));
    exp_q.delete();
    pend = 1'b0;
    next_cycle();
    ld_req = 1'b0;
    settle();

    next_cycle();
    resetN = 1'b1; cpu_readWriteN = 1'b1; cpu_address = 8'h14;
    settle();
    chk("after reset cpu_haltN", 32'(cpu_haltN), 32'(1));
    chk("after reset ld_grant", 32'(ld_grant), 32'(0));
    chk("after reset ram_address", 32'(ram_address), 32'(8'h14));
    chk("after reset ld_valid", 32'(ld_valid), 32'(0));

    next_cycle();
    ld_req = 1'b1; ld_readWriteN = 1'b1; ld_address = 8'h11;
    settle();
    chk("req in CPU cpu_haltN", 32'(cpu_haltN), 32'(1));
    next_cycle();
    settle();
    chk("drain cpu_haltN", 32'(cpu_haltN), 32'(0));
    chk("drain ld_grant", 32'(ld_grant), 32'(0));
    next_cycle();
    settle();
    chk("grant 2 cycles later", 32'(ld_grant), 32'(1));
    next_cycle();
    ld_req = 1'b0;
    settle();
    next_cycle();
    settle();
    chk("restore ld_grant", 32'(ld_grant), 32'(0));
    chk("restore cpu_haltN", 32'(cpu_haltN), 32'(0));
    next_cycle();
    settle();
    chk("resume cpu_haltN", 32'(cpu_haltN), 32'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
